// File: rtl/pipeline_hazard_ctrl_if.sv
// Issue/hazard control bus between the core datapath (master) and the hazard controller (slave).
// Ports: F-stage decode info, branch/memory status in; stall/flush/forward/writeback controls out.
// Combinational signalling only, no handshake latency of its own.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              f_valid;
    logic [REG_AW-1:0] f_rs1;
    logic [REG_AW-1:0] f_rs2;
    logic              f_use_rs1;
    logic              f_use_rs2;
    logic [REG_AW-1:0] f_rd;
    logic              f_wr_rd;
    logic              f_is_load;
    logic              branch_taken;
    logic              mem_ready;
    logic              stall_f;
    logic              flush_f;
    logic              e_valid_o;
    logic [1:0]        fwd_rs1;
    logic [1:0]        fwd_rs2;
    logic              wb_en;
    logic [REG_AW-1:0] wb_rd;
    logic [CNT_W-1:0]  stall_count;

    // Core side: presents the decoded F instruction, consumes the controls.
    modport master (
        output f_valid, f_rs1, f_rs2, f_use_rs1, f_use_rs2, f_rd, f_wr_rd, f_is_load,
               branch_taken, mem_ready,
        input  stall_f, flush_f, e_valid_o, fwd_rs1, fwd_rs2, wb_en, wb_rd, stall_count
    );

    // Hazard controller side.
    modport slave (
        input  f_valid, f_rs1, f_rs2, f_use_rs1, f_use_rs2, f_rd, f_wr_rd, f_is_load,
               branch_taken, mem_ready,
        output stall_f, flush_f, e_valid_o, fwd_rs1, fwd_rs2, wb_en, wb_rd, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Issue/hazard controller for the F->E->W core: tracks E/W destinations, selects operand forwarding,
// stalls F on load-use and on a load waiting for memory, squashes F on a taken branch, drives regfile write.
// Ports: clk, reset (sync, active-high), bus (slave modport). Outputs are combinational from state + F inputs.
module pipeline_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave bus
);
    // E and W slot state
    logic              e_vld, e_wr, e_ld;
    logic [REG_AW-1:0] e_rd;
    logic              w_vld, w_wr, w_ld;
    logic [REG_AW-1:0] w_rd;
    logic [CNT_W-1:0]  cnt;

    logic match_e1, match_e2, match_w1, match_w2;
    logic freeze, load_use, flush;

    // A source matches a slot only if it is really read, is not x0, and the slot will write it.
    assign match_e1 = bus.f_use_rs1 && (bus.f_rs1 != '0) && e_vld && e_wr && (e_rd == bus.f_rs1);
    assign match_e2 = bus.f_use_rs2 && (bus.f_rs2 != '0) && e_vld && e_wr && (e_rd == bus.f_rs2);
    assign match_w1 = bus.f_use_rs1 && (bus.f_rs1 != '0) && w_vld && w_wr && (w_rd == bus.f_rs1);
    assign match_w2 = bus.f_use_rs2 && (bus.f_rs2 != '0) && w_vld && w_wr && (w_rd == bus.f_rs2);

    // Whole pipe holds while the load in W waits on memory; this beats any branch or stall.
    assign freeze   = w_vld && w_ld && !bus.mem_ready;
    assign flush    = bus.branch_taken && !freeze;
    assign load_use = bus.f_valid && e_ld && (match_e1 || match_e2);

    assign bus.stall_f     = freeze || (!bus.branch_taken && load_use);
    assign bus.flush_f     = flush;
    assign bus.e_valid_o   = e_vld;
    assign bus.wb_en       = w_vld && w_wr && (w_rd != '0) && !freeze;
    assign bus.wb_rd       = w_rd;
    assign bus.stall_count = cnt;

    // A load in E has no result yet, so a match there falls through to W (the stall covers it anyway).
    always_comb begin
        bus.fwd_rs1 = 2'b00;
        if (match_e1 && !e_ld)  bus.fwd_rs1 = 2'b01;
        else if (match_w1)      bus.fwd_rs1 = 2'b10;
    end

    always_comb begin
        bus.fwd_rs2 = 2'b00;
        if (match_e2 && !e_ld)  bus.fwd_rs2 = 2'b01;
        else if (match_w2)      bus.fwd_rs2 = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_vld <= 1'b0;
            e_wr  <= 1'b0;
            e_ld  <= 1'b0;
            e_rd  <= '0;
            w_vld <= 1'b0;
            w_wr  <= 1'b0;
            w_ld  <= 1'b0;
            w_rd  <= '0;
            cnt   <= '0;
        end else begin
            if (bus.stall_f && (cnt != '1))
                cnt <= cnt + CNT_W'(1);
            if (!freeze) begin
                // E always retires into W when the pipe moves
                w_vld <= e_vld;
                w_wr  <= e_wr;
                w_ld  <= e_ld;
                w_rd  <= e_rd;
                if (flush || load_use) begin
                    // bubble: squashed wrong-path F or held dependent instruction
                    e_vld <= 1'b0;
                    e_wr  <= 1'b0;
                    e_ld  <= 1'b0;
                    e_rd  <= '0;
                end else begin
                    e_vld <= bus.f_valid;
                    e_wr  <= bus.f_wr_rd;
                    e_ld  <= bus.f_is_load;
                    e_rd  <= bus.f_rd;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
    localparam int AW = 5;
    localparam int CW = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();
    pipeline_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: an instruction occupying a pipeline stage.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       wr;
        bit       ld;
    } instr_t;

    instr_t stage_e, stage_w;
    int     stalls;

    // Does slot s produce the register that this operand reads?
    function automatic bit produces(bit use_rs, bit [4:0] rs, instr_t s);
        return use_rs && rs != 0 && s.v && s.wr && s.rd == rs;
    endfunction

    function automatic bit [1:0] src_of(bit use_rs, bit [4:0] rs);
        if (produces(use_rs, rs, stage_e) && !stage_e.ld) return 2'd1;
        if (produces(use_rs, rs, stage_w)) return 2'd2;
        return 2'd0;
    endfunction

    // DUT outputs captured in the last step, for directed checks
    logic       o_stall, o_flush, o_ev, o_wb;
    logic [1:0] o_f1, o_f2;
    logic [4:0] o_wbrd;
    logic [5:0] o_cnt;

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic step();
        bit waiting, dep, exp_stall, exp_flush, exp_wb;
        instr_t f;
        @(negedge clk);
        waiting   = stage_w.v && stage_w.ld && !bus.mem_ready;
        dep       = bus.f_valid && stage_e.ld &&
                    (produces(bus.f_use_rs1, bus.f_rs1, stage_e) || produces(bus.f_use_rs2, bus.f_rs2, stage_e));
        exp_flush = bus.branch_taken && !waiting;
        exp_stall = waiting || (dep && !bus.branch_taken);
        exp_wb    = stage_w.v && stage_w.wr && stage_w.rd != 0 && !waiting;
        o_stall = bus.stall_f; o_flush = bus.flush_f; o_ev = bus.e_valid_o; o_wb = bus.wb_en;
        o_f1 = bus.fwd_rs1; o_f2 = bus.fwd_rs2; o_wbrd = bus.wb_rd; o_cnt = bus.stall_count;
        chk("stall_f", 32'(bus.stall_f), 32'(exp_stall));
        chk("flush_f", 32'(bus.flush_f), 32'(exp_flush));
        chk("e_valid", 32'(bus.e_valid_o), 32'(stage_e.v));
        chk("fwd_rs1", 32'(bus.fwd_rs1), 32'(src_of(bus.f_use_rs1, bus.f_rs1)));
        chk("fwd_rs2", 32'(bus.fwd_rs2), 32'(src_of(bus.f_use_rs2, bus.f_rs2)));
        chk("wb_en", 32'(bus.wb_en), 32'(exp_wb));
        if (exp_wb) chk("wb_rd", 32'(bus.wb_rd), 32'(stage_w.rd));
        chk("stall_count", 32'(bus.stall_count), 32'(stalls));
        f.v = bus.f_valid; f.rd = bus.f_rd; f.wr = bus.f_wr_rd; f.ld = bus.f_is_load;
        if (reset) begin
            stage_e = '{default: 0};
            stage_w = '{default: 0};
            stalls  = 0;
        end else begin
            if (exp_stall) stalls = (stalls == CMAX) ? CMAX : stalls + 1;
            if (!waiting) begin
                stage_w = stage_e;
                if (exp_flush || dep) stage_e = '{default: 0};
                else                  stage_e = f;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_f(input bit v, input bit [4:0] rs1, input bit u1, input bit [4:0] rs2,
                         input bit u2, input bit [4:0] rd, input bit wr, input bit ld);
        bus.f_valid = v; bus.f_rs1 = rs1; bus.f_use_rs1 = u1; bus.f_rs2 = rs2;
        bus.f_use_rs2 = u2; bus.f_rd = rd; bus.f_wr_rd = wr; bus.f_is_load = ld;
    endtask

    task automatic idle();
        set_f(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int base;
    bit saw9;

    initial begin
        reset = 1'b1;
        idle();
        bus.branch_taken = 1'b0;
        bus.mem_ready = 1'b1;
        stage_e = '{default: 0};
        stage_w = '{default: 0};
        stalls = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        step();
        chk("rst_stall", 32'(o_stall), 0);
        chk("rst_wb", 32'(o_wb), 0);
        chk("rst_ev", 32'(o_ev), 0);
        chk("rst_fwd", 32'({o_f1, o_f2}), 0);

        // ALU result forwarded from E with no stall
        set_f(1, 1, 1, 2, 1, 5, 1, 0); step();           // add x5,x1,x2
        set_f(1, 5, 1, 1, 1, 6, 1, 0); step();           // sub x6,x5,x1
        chk("alu_fwd1", 32'(o_f1), 1);
        chk("alu_fwd2", 32'(o_f2), 0);
        chk("alu_stall", 32'(o_stall), 0);
        idle(); step();

        // load-use: exactly one stall, then forward from W
        set_f(1, 0, 0, 0, 0, 7, 1, 1); step();           // lw x7
        set_f(1, 7, 1, 7, 1, 8, 1, 0); step();           // add x8,x7,x7
        chk("lu_stall", 32'(o_stall), 1);
        step();
        chk("lu_release", 32'(o_stall), 0);
        chk("lu_bubble", 32'(o_ev), 0);
        chk("lu_fwd1", 32'(o_f1), 2);
        chk("lu_fwd2", 32'(o_f2), 2);
        idle(); step(); step();

        // x0 destination never forwarded nor written
        set_f(1, 0, 0, 0, 0, 0, 1, 0); step();           // addi x0
        set_f(1, 0, 1, 0, 1, 1, 1, 0); step();
        chk("x0_fwd", 32'({o_f1, o_f2}), 0);
        chk("x0_stall", 32'(o_stall), 0);
        idle(); step();
        chk("x0_wb", 32'(o_wb), 0);
        step();

        // taken branch squashes F (rd=x9)
        set_f(1, 0, 0, 0, 0, 9, 1, 0);
        bus.branch_taken = 1'b1; step();
        chk("br_flush", 32'(o_flush), 1);
        bus.branch_taken = 1'b0; idle(); step();
        chk("br_bubble", 32'(o_ev), 0);
        saw9 = 0;
        repeat (3) begin
            step();
            if (o_wb && o_wbrd == 5'd9) saw9 = 1;
        end
        chk("br_no_x9", 32'(saw9), 0);

        // load in W waiting three cycles on memory
        set_f(1, 0, 0, 0, 0, 3, 1, 1); step();           // lw x3
        idle(); step();                                   // lw x3 now in W
        base = stalls;
        bus.mem_ready = 1'b0;
        repeat (3) begin
            step();
            chk("mw_stall", 32'(o_stall), 1);
            chk("mw_wb", 32'(o_wb), 0);
        end
        bus.mem_ready = 1'b1; step();
        chk("mw_wb_rel", 32'(o_wb), 1);
        chk("mw_wb_rd", 32'(o_wbrd), 3);
        chk("mw_cnt", 32'(o_cnt), 32'(base + 3));

        // reset while frozen drops the held load
        set_f(1, 0, 0, 0, 0, 4, 1, 1); step();
        idle(); step();
        bus.mem_ready = 1'b0;
        step(); step();
        reset = 1'b1; step();
        reset = 1'b0; step();
        chk("rf_wb", 32'(o_wb), 0);
        chk("rf_stall", 32'(o_stall), 0);
        chk("rf_cnt", 32'(o_cnt), 0);

        // saturation of the stall counter
        bus.mem_ready = 1'b1;
        set_f(1, 0, 0, 0, 0, 2, 1, 1); step();
        idle(); step();
        bus.mem_ready = 1'b0;
        repeat (CMAX + 10) step();
        chk("sat_cnt", 32'(o_cnt), CMAX);
        bus.mem_ready = 1'b1; step();
        chk("sat_hold", 32'(o_cnt), CMAX);

        // randomized traffic over a small register set to provoke hazards
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            set_f($urandom_range(0, 3) != 0, 5'($urandom_range(0, 6)), 1'($urandom),
                  5'($urandom_range(0, 6)), 1'($urandom), 5'($urandom_range(0, 6)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            bus.branch_taken = $urandom_range(0, 9) == 0;
            bus.mem_ready = $urandom_range(0, 3) != 0;
            reset = $urandom_range(0, 199) == 0;
            step();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
